// File: rtl/ai_player_m_pkg.sv
// Shared types and constants for the automated tic-tac-toe opponent:
// cell marks, move kinds, FSM states, win-line table and preference order.
package ai_player_m_pkg;

  typedef logic [1:0]      cell_t;
  typedef logic            flag_t;
  typedef logic [3:0]      index_t;
  typedef logic [8:0][1:0] board_t;

  localparam cell_t CELL_BLANK = 2'd0;
  localparam cell_t CELL_X     = 2'd1;
  localparam cell_t CELL_O     = 2'd2;

  localparam flag_t TURN_PLAYER = 1'b0;
  localparam flag_t TURN_AI     = 1'b1;

  localparam cell_t  AI_CELL       = CELL_O;
  localparam index_t INDEX_INVALID = 4'hF;

  typedef enum logic [1:0] {
    MOVE_WIN   = 2'd0,
    MOVE_BLOCK = 2'd1,
    MOVE_PREF  = 2'd2,
    MOVE_NONE  = 2'd3
  } move_kind_t;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SCAN_WIN   = 3'd1,
    ST_SCAN_BLOCK = 3'd2,
    ST_PREF       = 3'd3,
    ST_SUBMIT     = 3'd4,
    ST_HOLD       = 3'd5,
    ST_WAIT_TURN  = 3'd6
  } state_t;

  // Rows, then columns, then the two diagonals; scan order matters for latency.
  localparam index_t WIN_LINES [8][3] = '{
    '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
  };

  localparam index_t PREF_ORDER [9] = '{
    4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7
  };

endpackage

// File: rtl/ai_player_m_if.sv
// Move-request link between the board and the automated player.
interface ai_player_m_if;
  import ai_player_m_pkg::*;

  // The board drives turn/board; the player answers with update_loc held
  // stable while submit is high and for one cycle after it falls.
  // The board commits update_loc on the falling edge of submit; there is no
  // ready/back-pressure, the return of turn to the player acts as the ack.
  flag_t  turn;
  board_t board;
  index_t update_loc;
  flag_t  submit;

  modport master (input turn, input board, output update_loc, output submit);
  modport slave  (output turn, output board, input update_loc, input submit);
endinterface

// File: rtl/ai_player_m_line_eval.sv
// Combinational check of one win line: two cells of the target mark plus
// exactly one blank is a hit, and the blank is the cell to play.
module line_eval_m
  import ai_player_m_pkg::*;
(
  input  cell_t  i_cell_a,
  input  cell_t  i_cell_b,
  input  cell_t  i_cell_c,
  input  index_t i_idx_a,
  input  index_t i_idx_b,
  input  index_t i_idx_c,
  input  cell_t  i_mark,
  output logic   o_hit,
  output index_t o_blank_idx
);
  logic [1:0] w_n_mark;
  logic [1:0] w_n_blank;

  assign w_n_mark  = 2'(i_cell_a == i_mark) + 2'(i_cell_b == i_mark)
                   + 2'(i_cell_c == i_mark);
  assign w_n_blank = 2'(i_cell_a == CELL_BLANK) + 2'(i_cell_b == CELL_BLANK)
                   + 2'(i_cell_c == CELL_BLANK);

  assign o_hit       = (w_n_mark == 2'd2) && (w_n_blank == 2'd1);
  assign o_blank_idx = (i_cell_a == CELL_BLANK) ? i_idx_a :
                       (i_cell_b == CELL_BLANK) ? i_idx_b : i_idx_c;
endmodule

// File: rtl/ai_player_m.sv
// Automated opponent: snapshots the board on its turn, scans one win line per
// clock (own wins, then blocks), falls back to positional preference, submits.
module ai_player_m #(
  parameter int                     SUBMIT_CYCLES = 2,
  parameter int                     TIMEOUT       = 16,
  parameter ai_player_m_pkg::cell_t AI_CELL       = ai_player_m_pkg::AI_CELL
) (
  input  logic                     clk,
  input  logic                     reset,
  ai_player_m_if.master            mv,
  output logic                     o_busy,
  output logic [1:0]               o_move_kind,
  output logic                     o_no_move,
  output logic                     o_timeout_err,
  output ai_player_m_pkg::state_t  o_state
);
  import ai_player_m_pkg::*;

  localparam int SW = (SUBMIT_CYCLES > 1) ? $clog2(SUBMIT_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] SUB_LAST = SW'(SUBMIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);
  localparam cell_t OPP_CELL = (AI_CELL == CELL_O) ? CELL_X : CELL_O;

  state_t        r_state, w_state;
  board_t        r_snap, w_snap;
  logic [2:0]    r_line_idx, w_line_idx;
  logic [SW-1:0] r_sub_cnt, w_sub_cnt;
  logic [TW-1:0] r_to_cnt, w_to_cnt;
  index_t        r_update_loc, w_update_loc;
  logic          r_submit, w_submit;
  logic          r_busy, w_busy;
  move_kind_t    r_move_kind, w_move_kind;
  logic          r_no_move, w_no_move;
  logic          r_timeout_err, w_timeout_err;

  logic   w_hit;
  index_t w_blank_idx;
  cell_t  w_mark;
  logic   w_pref_found;
  index_t w_pref_idx;

  assign w_mark = (r_state == ST_SCAN_BLOCK) ? OPP_CELL : AI_CELL;

  line_eval_m u_line_eval (
    .i_cell_a    (r_snap[WIN_LINES[r_line_idx][0]]),
    .i_cell_b    (r_snap[WIN_LINES[r_line_idx][1]]),
    .i_cell_c    (r_snap[WIN_LINES[r_line_idx][2]]),
    .i_idx_a     (WIN_LINES[r_line_idx][0]),
    .i_idx_b     (WIN_LINES[r_line_idx][1]),
    .i_idx_c     (WIN_LINES[r_line_idx][2]),
    .i_mark      (w_mark),
    .o_hit       (w_hit),
    .o_blank_idx (w_blank_idx)
  );

  always_comb begin
    w_pref_found = 1'b0;
    w_pref_idx   = INDEX_INVALID;
    for (int p = 0; p < 9; p++) begin
      if (!w_pref_found && r_snap[PREF_ORDER[p]] == CELL_BLANK) begin
        w_pref_found = 1'b1;
        w_pref_idx   = PREF_ORDER[p];
      end
    end
  end

  always_comb begin
    w_state       = r_state;
    w_snap        = r_snap;
    w_line_idx    = r_line_idx;
    w_sub_cnt     = r_sub_cnt;
    w_to_cnt      = r_to_cnt;
    w_update_loc  = r_update_loc;
    w_submit      = r_submit;
    w_move_kind   = r_move_kind;
    w_no_move     = 1'b0;
    w_timeout_err = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mv.turn == TURN_AI) begin
          w_snap     = mv.board;
          w_line_idx = 3'd0;
          w_state    = ST_SCAN_WIN;
        end
      end
      ST_SCAN_WIN, ST_SCAN_BLOCK: begin
        if (mv.turn == TURN_PLAYER) begin
          w_state = ST_IDLE;
        end else if (w_hit) begin
          w_update_loc = w_blank_idx;
          w_move_kind  = (r_state == ST_SCAN_WIN) ? MOVE_WIN : MOVE_BLOCK;
          w_submit     = 1'b1;
          w_sub_cnt    = '0;
          w_state      = ST_SUBMIT;
        end else begin
          // Wraps 7 -> 0 exactly when the phase changes.
          w_line_idx = r_line_idx + 3'd1;
          if (r_line_idx == 3'd7)
            w_state = (r_state == ST_SCAN_WIN) ? ST_SCAN_BLOCK : ST_PREF;
        end
      end
      ST_PREF: begin
        if (mv.turn == TURN_PLAYER) begin
          w_state = ST_IDLE;
        end else if (w_pref_found) begin
          w_update_loc = w_pref_idx;
          w_move_kind  = MOVE_PREF;
          w_submit     = 1'b1;
          w_sub_cnt    = '0;
          w_state      = ST_SUBMIT;
        end else begin
          w_no_move = 1'b1;
          w_state   = ST_IDLE;
        end
      end
      ST_SUBMIT: begin
        if (r_sub_cnt == SUB_LAST) begin
          w_submit = 1'b0;
          w_state  = ST_HOLD;
        end else begin
          w_sub_cnt = r_sub_cnt + 1'b1;
        end
      end
      ST_HOLD: begin
        w_update_loc = INDEX_INVALID;
        w_move_kind  = MOVE_NONE;
        w_to_cnt     = '0;
        w_state      = ST_WAIT_TURN;
      end
      ST_WAIT_TURN: begin
        if (mv.turn == TURN_PLAYER) begin
          w_state = ST_IDLE;
        end else if (r_to_cnt == TO_LAST) begin
          w_timeout_err = 1'b1;
          w_state       = ST_IDLE;
        end else if (r_to_cnt != TO_MAX) begin
          w_to_cnt = r_to_cnt + 1'b1;
        end
      end
      default: w_state = ST_IDLE;
    endcase
    w_busy = (w_state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_snap        <= '0;
      r_line_idx    <= 3'd0;
      r_sub_cnt     <= '0;
      r_to_cnt      <= '0;
      r_update_loc  <= INDEX_INVALID;
      r_submit      <= 1'b0;
      r_busy        <= 1'b0;
      r_move_kind   <= MOVE_NONE;
      r_no_move     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_snap        <= w_snap;
      r_line_idx    <= w_line_idx;
      r_sub_cnt     <= w_sub_cnt;
      r_to_cnt      <= w_to_cnt;
      r_update_loc  <= w_update_loc;
      r_submit      <= w_submit;
      r_busy        <= w_busy;
      r_move_kind   <= w_move_kind;
      r_no_move     <= w_no_move;
      r_timeout_err <= w_timeout_err;
    end
  end

  assign mv.update_loc   = r_update_loc;
  assign mv.submit       = r_submit;
  assign o_busy          = r_busy;
  assign o_move_kind     = r_move_kind;
  assign o_no_move       = r_no_move;
  assign o_timeout_err   = r_timeout_err;
  assign o_state         = r_state;
endmodule

// File: tb/tb_ai_player_m.sv
// Bench for ai_player_m: a move-selection model plus a per-edge expected
// output trace, checked by one compare process on the falling clock edge.
module tb_ai_player_m;
  import ai_player_m_pkg::*;

  localparam int S  = 2;
  localparam int TO = 16;
  localparam int LINES [8][3] = '{
    '{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}
  };
  localparam int PREF [9] = '{4,0,2,6,8,1,3,5,7};

  logic       clk;
  logic       reset;
  logic       o_busy;
  logic [1:0] o_move_kind;
  logic       o_no_move;
  logic       o_timeout_err;
  state_t     o_state;

  ai_player_m_if mv();

  ai_player_m #(.SUBMIT_CYCLES(S), .TIMEOUT(TO), .AI_CELL(CELL_O)) dut (
    .clk           (clk),
    .reset         (reset),
    .mv            (mv),
    .o_busy        (o_busy),
    .o_move_kind   (o_move_kind),
    .o_no_move     (o_no_move),
    .o_timeout_err (o_timeout_err),
    .o_state       (o_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard: [10]=check kind [9]=busy [8]=submit [7:4]=loc [3:2]=kind [1]=no_move [0]=timeout
  logic [10:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(negedge clk) begin
    logic [10:0] e;
    logic [9:0]  act, mask;
    cyc++;
    if (exp_q.size() != 0) begin
      e    = exp_q.pop_front();
      act  = {o_busy, mv.submit, mv.update_loc, o_move_kind, o_no_move, o_timeout_err};
      mask = e[10] ? 10'h3FF : 10'h3F3;
      total++;
      if ((act & mask) !== (e[9:0] & mask)) begin
        bad++;
        $display("FAIL outputs cyc=%0d busy/sub/loc/kind/nm/to got=%b/%b/%h/%0d/%b/%b want=%b/%b/%h/%0d/%b/%b",
                 cyc, act[9], act[8], act[7:4], act[3:2], act[1], act[0],
                 e[9], e[8], e[7:4], e[3:2], e[1], e[0]);
      end
    end
  end

  // behavioural move selection
  function automatic void find_move(input board_t b, output int kind, output int loc,
                                    output int lat);
    kind = 3; loc = 15; lat = 17;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 8; i++) begin
        int nm = 0, nb = 0, bi = 15;
        for (int j = 0; j < 3; j++) begin
          if (b[LINES[i][j]] == (pass == 0 ? CELL_O : CELL_X)) nm++;
          else if (b[LINES[i][j]] == CELL_BLANK) begin nb++; bi = LINES[i][j]; end
        end
        if (nm == 2 && nb == 1) begin
          kind = pass; loc = bi; lat = 1 + 8 * pass + i;
          return;
        end
      end
    end
    for (int p = 0; p < 9; p++) begin
      if (b[PREF[p]] == CELL_BLANK) begin
        kind = 2; loc = PREF[p];
        return;
      end
    end
  endfunction

  function automatic board_t mk(input string s);
    board_t b;
    for (int i = 0; i < 9; i++)
      b[i] = (s[i] == "O") ? CELL_O : (s[i] == "X") ? CELL_X : CELL_BLANK;
    return b;
  endfunction

  function automatic board_t rand_board();
    board_t b;
    for (int c = 0; c < 9; c++) b[c] = 2'($urandom_range(0, 2));
    return b;
  endfunction

  task automatic pin(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL model_%s got=%0d want=%0d", name, got, want);
    end
  endtask

  // driver tasks
  task automatic step(input bit busy, input bit sub, input int loc, input int kind,
                      input bit nm, input bit to, input bit kc);
    @(posedge clk);
    exp_q.push_back({kc, busy, sub, 4'(loc), 2'(kind), nm, to});
    #1;
  endtask

  task automatic idle_step();
    step(0, 0, 15, 3, 0, 0, 0);
  endtask

  task automatic busy_step();
    step(1, 0, 15, 3, 0, 0, 0);
  endtask

  // One AI turn from IDLE. abort_at: edge offset where turn drops (0 = none);
  // back_at: wait cycle on which turn returns to player (0 = never).
  task automatic ai_round(input board_t b, input int abort_at, input int back_at);
    int kind, loc, lat;
    find_move(b, kind, loc, lat);
    mv.board = b;
    mv.turn  = TURN_AI;
    busy_step();
    mv.board = rand_board();
    if (abort_at > 0 && abort_at <= lat) begin
      for (int e = 1; e < abort_at; e++) busy_step();
      mv.turn = TURN_PLAYER;
      idle_step();
      return;
    end
    for (int e = 1; e < lat; e++) busy_step();
    if (kind == 3) begin
      step(0, 0, 15, 3, 1, 0, 0);
      return;
    end
    for (int s = 0; s < S; s++) step(1, 1, loc, kind, 0, 0, 1);
    step(1, 0, loc, kind, 0, 0, 0);
    busy_step();
    for (int n = 1; n <= TO; n++) begin
      if (n == back_at) begin
        mv.turn = TURN_PLAYER;
        idle_step();
        return;
      end else if (n == TO) begin
        step(0, 0, 15, 3, 0, 1, 0);
        return;
      end else begin
        busy_step();
      end
    end
  endtask

  task automatic settle();
    mv.turn = TURN_PLAYER;
    idle_step();
  endtask

  initial begin
    int k, l, t;
    reset    = 1'b1;
    mv.turn  = TURN_PLAYER;
    mv.board = '0;
    step(0, 0, 15, 3, 0, 0, 1);
    step(0, 0, 15, 3, 0, 0, 1);
    reset = 1'b0;
    idle_step();

    // model pins
    find_move(mk("OO.XX...."), k, l, t);
    pin("win_loc", l, 2); pin("win_kind", k, 0); pin("win_lat", t, 1);
    find_move(mk("X.O.X...."), k, l, t);
    pin("blk_loc", l, 8); pin("blk_kind", k, 1); pin("blk_lat", t, 15);
    find_move(mk("........."), k, l, t);
    pin("empty_loc", l, 4); pin("empty_lat", t, 17);
    find_move(mk("....X...."), k, l, t);
    pin("x4_loc", l, 0); pin("x4_kind", k, 2);
    find_move(mk("XOXXOOOXX"), k, l, t);
    pin("full_kind", k, 3);

    // directed scenarios
    ai_round(mk("OO.XX...."), 0, 2);  settle();
    ai_round(mk("X.O.X...."), 0, 1);  settle();
    ai_round(mk("........."), 0, 3);  settle();
    ai_round(mk("....X...."), 0, 5);  settle();
    ai_round(mk("XOXXOOOXX"), 0, 0);  settle();
    ai_round(mk("OO.XX...."), 0, 0);
    ai_round(mk("OO.XX...."), 0, 4);  settle();
    ai_round(mk("X.O.X...."), 4, 0);  settle();
    ai_round(mk("XOXXOOOXX"), 17, 0); settle();

    // reset while submit is high
    mv.board = mk("OO.XX....");
    mv.turn  = TURN_AI;
    busy_step();
    step(1, 1, 2, 0, 0, 0, 1);
    reset   = 1'b1;
    mv.turn = TURN_PLAYER;
    step(0, 0, 15, 3, 0, 0, 1);
    step(0, 0, 15, 3, 0, 0, 1);
    reset = 1'b0;
    idle_step();

    // randomized turns
    for (int r = 0; r < 40; r++) begin
      int ab;
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 18)) : 0;
      ai_round(rand_board(), ab, int'($urandom_range(1, 20)));
      settle();
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
